// File: rtl/stack_row_controller_if.sv
// stack_row_controller_if: handshake and status bundle between the row controller and its neighbours.
interface stack_row_controller_if #(
  parameter int COLS = 10,
  parameter int ROWS = 12
);
  logic                    enable_frame;
  logic                    start;
  logic                    place;
  logic [31:0]             speed_count;
  logic                    counter_enable;
  logic [COLS-1:0]         row_mask;
  logic [$clog2(ROWS)-1:0] row_index;
  logic [COLS-1:0]         locked_mask;
  logic [$clog2(ROWS)-1:0] locked_row;
  logic                    wr_en;
  logic                    game_over;
  logic                    win;
  modport master (
    output enable_frame, start, place,
    input  speed_count, counter_enable, row_mask, row_index,
           locked_mask, locked_row, wr_en, game_over, win
  );
  modport slave (
    input  enable_frame, start, place,
    output speed_count, counter_enable, row_mask, row_index,
           locked_mask, locked_row, wr_en, game_over, win
  );
endinterface

// File: rtl/stack_row_controller.sv
// stack_row_controller: slides the active segment across a row, locks it against the row below and speeds up play.
module stack_row_controller #(
  parameter int          COLS        = 10,
  parameter int          ROWS        = 12,
  parameter int          INIT_WIDTH  = 3,
  parameter logic [31:0] START_SPEED = 32'd833332,
  parameter logic [31:0] SPEED_STEP  = 32'd50000,
  parameter logic [31:0] MIN_SPEED   = 32'd100000
) (
  input  logic                         clk,
  input  logic                         resetn,
  stack_row_controller_if.slave        bus
);
  localparam int PW = $clog2(COLS);
  localparam int WW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS);
  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_LOCK, S_OVER, S_WIN} state_t;
  state_t          r_state;
  logic [PW-1:0]   r_pos;
  logic [WW-1:0]   r_width;
  logic            r_dir;
  logic [COLS-1:0] r_prev_mask;
  logic            r_place_d;
  logic [RW-1:0]   r_row;
  logic [COLS-1:0] r_locked_mask;
  logic [RW-1:0]   r_locked_row;
  logic [31:0]     r_speed;
  logic            r_wr_en;
  logic            r_cen;
  logic            r_game_over;
  logic            r_win;
  logic [COLS-1:0] w_ones;
  logic [COLS-1:0] w_row_mask;
  logic            w_edge;
  logic            w_at_right;
  logic            w_last;
  logic [WW-1:0]   w_pop;
  logic [32:0]     w_floor;
  logic [31:0]     w_next_speed;
  always_comb begin
    w_ones       = {COLS{1'b1}} >> (COLS - int'(r_width));
    w_row_mask   = (r_state == S_MOVE || r_state == S_LOCK) ? (w_ones << r_pos) : '0;
    w_edge       = bus.place & ~r_place_d;
    w_at_right   = (int'(r_pos) + int'(r_width)) == COLS;
    w_last       = int'(r_row) == ROWS - 1;
    w_pop        = '0;
    for (int i = 0; i < COLS; i++) w_pop = w_pop + WW'(r_locked_mask[i]);
    // compare in 33 bits so the floor test cannot underflow
    w_floor      = {1'b0, MIN_SPEED} + {1'b0, SPEED_STEP};
    w_next_speed = ({1'b0, r_speed} >= w_floor) ? r_speed - SPEED_STEP : MIN_SPEED;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_pos         <= '0;
      r_width       <= WW'(INIT_WIDTH);
      r_dir         <= 1'b0;
      r_prev_mask   <= '1;
      r_place_d     <= 1'b0;
      r_row         <= '0;
      r_locked_mask <= '0;
      r_locked_row  <= '0;
      r_speed       <= START_SPEED;
      r_wr_en       <= 1'b0;
      r_cen         <= 1'b0;
      r_game_over   <= 1'b0;
      r_win         <= 1'b0;
    end else begin
      r_place_d <= bus.place;
      case (r_state)
        S_MOVE: begin
          if (w_edge) begin
            r_locked_mask <= w_row_mask & r_prev_mask;
            r_locked_row  <= r_row;
            r_wr_en       <= 1'b1;
            r_cen         <= 1'b0;
            r_state       <= S_LOCK;
          end else if (bus.enable_frame) begin
            if (!r_dir) begin
              r_dir <= w_at_right;
              r_pos <= w_at_right ? r_pos - 1'b1 : r_pos + 1'b1;
            end else begin
              r_dir <= r_pos != '0;
              r_pos <= (r_pos == '0) ? PW'(1) : r_pos - 1'b1;
            end
          end
        end
        S_LOCK: begin
          r_wr_en <= 1'b0;
          if (r_locked_mask == '0) begin
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else if (w_last) begin
            r_win   <= 1'b1;
            r_state <= S_WIN;
          end else begin
            r_row       <= r_row + 1'b1;
            r_pos       <= '0;
            r_dir       <= 1'b0;
            r_width     <= w_pop;
            r_prev_mask <= r_locked_mask;
            r_speed     <= w_next_speed;
            r_cen       <= 1'b1;
            r_state     <= S_MOVE;
          end
        end
        default: begin
          if (bus.start) begin
            r_pos       <= '0;
            r_width     <= WW'(INIT_WIDTH);
            r_dir       <= 1'b0;
            r_row       <= '0;
            r_prev_mask <= '1;
            r_speed     <= START_SPEED;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
            r_cen       <= 1'b1;
            r_state     <= S_MOVE;
          end
        end
      endcase
    end
  end
  assign bus.speed_count    = r_speed;
  assign bus.counter_enable = r_cen;
  assign bus.row_mask       = w_row_mask;
  assign bus.row_index      = r_row;
  assign bus.locked_mask    = r_locked_mask;
  assign bus.locked_row     = r_locked_row;
  assign bus.wr_en          = r_wr_en;
  assign bus.game_over      = r_game_over;
  assign bus.win            = r_win;
endmodule

// File: tb/tb_stack_row_controller.sv
// tb_stack_row_controller: directed checks of movement, locking, trimming, speed-up, win/lose and reset.
module tb_stack_row_controller;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  stack_row_controller_if #(.COLS(10), .ROWS(12)) a_if ();
  stack_row_controller_if #(.COLS(10), .ROWS(2))  b_if ();
  stack_row_controller_if #(.COLS(10), .ROWS(12)) c_if ();
  stack_row_controller #(.COLS(10), .ROWS(12)) u_a (.clk(clk), .resetn(resetn), .bus(a_if.slave));
  stack_row_controller #(.COLS(10), .ROWS(2))  u_b (.clk(clk), .resetn(resetn), .bus(b_if.slave));
  stack_row_controller #(.COLS(10), .ROWS(12), .SPEED_STEP(32'd500000)) u_c (.clk(clk), .resetn(resetn), .bus(c_if.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic ef, input logic st, input logic pl);
    a_if.enable_frame = ef;
    a_if.start = st;
    a_if.place = pl;
    @(posedge clk);
    #1;
  endtask
  task automatic tick2(input logic st, input logic pl);
    b_if.start = st;
    b_if.place = pl;
    c_if.start = st;
    c_if.place = pl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    a_if.enable_frame = 0; a_if.start = 0; a_if.place = 0;
    b_if.enable_frame = 0; b_if.start = 0; b_if.place = 0;
    c_if.enable_frame = 0; c_if.start = 0; c_if.place = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_row_mask", a_if.row_mask, 0);
    chk("rst_cen", a_if.counter_enable, 0);
    chk("rst_speed", a_if.speed_count, 833332);
    chk("rst_wr_en", a_if.wr_en, 0);
    chk("rst_row_index", a_if.row_index, 0);
    chk("rst_over_win", {a_if.game_over, a_if.win}, 0);
    resetn = 1'b1;
    tick(0, 1, 0);
    chk("start_mask", a_if.row_mask, 10'b0000000111);
    chk("start_cen", a_if.counter_enable, 1);
    chk("start_speed", a_if.speed_count, 833332);
    chk("start_row", a_if.row_index, 0);
    repeat (7) tick(1, 0, 0);
    chk("right_edge", a_if.row_mask, 10'b1110000000);
    tick(1, 0, 0);
    chk("bounce_left", a_if.row_mask, 10'b0111000000);
    tick(0, 0, 0);
    chk("no_tick_hold", a_if.row_mask, 10'b0111000000);
    repeat (4) tick(1, 0, 0);
    chk("at_pos2", a_if.row_mask, 10'b0000011100);
    tick(0, 0, 1);
    chk("lock0_wr", a_if.wr_en, 1);
    chk("lock0_mask", a_if.locked_mask, 10'b0000011100);
    chk("lock0_row", a_if.locked_row, 0);
    chk("lock0_cen", a_if.counter_enable, 0);
    tick(0, 0, 1);
    chk("row1_wr", a_if.wr_en, 0);
    chk("row1_index", a_if.row_index, 1);
    chk("row1_mask", a_if.row_mask, 10'b0000000111);
    chk("row1_speed", a_if.speed_count, 783332);
    chk("row1_cen", a_if.counter_enable, 1);
    tick(1, 0, 1);
    chk("held_no_relock", a_if.wr_en, 0);
    chk("held_moves", a_if.row_mask, 10'b0000001110);
    tick(0, 0, 0);
    repeat (2) tick(1, 0, 0);
    chk("row1_pos3", a_if.row_mask, 10'b0000111000);
    tick(1, 0, 1);
    chk("coinc_wr", a_if.wr_en, 1);
    chk("coinc_unmoved", a_if.row_mask, 10'b0000111000);
    chk("partial_mask", a_if.locked_mask, 10'b0000011000);
    chk("partial_row", a_if.locked_row, 1);
    tick(0, 0, 0);
    chk("row2_index", a_if.row_index, 2);
    chk("row2_mask", a_if.row_mask, 10'b0000000011);
    chk("row2_speed", a_if.speed_count, 733332);
    repeat (6) tick(1, 0, 0);
    chk("row2_pos6", a_if.row_mask, 10'b0011000000);
    tick(0, 0, 1);
    chk("miss_wr", a_if.wr_en, 1);
    chk("miss_mask", a_if.locked_mask, 0);
    chk("miss_row", a_if.locked_row, 2);
    tick(0, 0, 0);
    chk("over_flag", a_if.game_over, 1);
    chk("over_cen", a_if.counter_enable, 0);
    chk("over_row_mask", a_if.row_mask, 0);
    chk("over_wr", a_if.wr_en, 0);
    tick(0, 0, 1);
    chk("over_place_ign", a_if.wr_en, 0);
    chk("over_locked_row", a_if.locked_row, 2);
    chk("over_still", a_if.game_over, 1);
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("restart_over", a_if.game_over, 0);
    chk("restart_mask", a_if.row_mask, 10'b0000000111);
    chk("restart_speed", a_if.speed_count, 833332);
    chk("restart_row", a_if.row_index, 0);
    repeat (14) tick(1, 0, 0);
    chk("left_edge", a_if.row_mask, 10'b0000000111);
    tick(1, 0, 0);
    chk("bounce_right", a_if.row_mask, 10'b0000001110);
    tick(1, 0, 0);
    chk("right_again", a_if.row_mask, 10'b0000011100);
    tick(0, 0, 1);
    chk("lock_pre_rst", a_if.wr_en, 1);
    resetn = 1'b0;
    #1;
    chk("async_rst_wr", a_if.wr_en, 0);
    chk("async_rst_mask", a_if.row_mask, 0);
    chk("async_rst_locked", a_if.locked_mask, 0);
    chk("async_rst_cen", a_if.counter_enable, 0);
    a_if.place = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick(0, 0, 0);
    chk("idle_after_rst", a_if.row_mask, 0);
    tick2(1, 0);
    chk("c_start_speed", c_if.speed_count, 833332);
    tick2(0, 1);
    chk("b_lock0_mask", b_if.locked_mask, 10'b0000000111);
    tick2(0, 0);
    chk("b_row1", b_if.row_index, 1);
    chk("c_speed1", c_if.speed_count, 333332);
    tick2(0, 1);
    chk("b_lock1_wr", b_if.wr_en, 1);
    tick2(0, 0);
    chk("b_win", b_if.win, 1);
    chk("b_win_cen", b_if.counter_enable, 0);
    chk("b_win_mask", b_if.row_mask, 0);
    chk("c_clamp", c_if.speed_count, 100000);
    tick2(0, 1);
    tick2(0, 0);
    chk("c_clamp_hold", c_if.speed_count, 100000);
    chk("c_row3", c_if.row_index, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stack_row_controller.md
# stack_row_controller

Game-row controller for the block stacker, directly downstream of the frame delay counter. It consumes the one-cycle `enable_frame` tick to slide the active block segment left/right across the current row. On a `place` press it locks the segment against the row below, trims overhang, and advances to the next row. It drives `speed_count` and `counter_enable` back into the delay counter, so play speeds up each row.

## Interface
Parameters:
- `COLS`, 10: board width in cells; column 0 is the LSB of every mask.
- `ROWS`, 12: number of rows to win.
- `INIT_WIDTH`, 3: starting segment width; must be ≥1 and < `COLS`.
- `START_SPEED`, 32'd833332: `speed_count` loaded at start.
- `SPEED_STEP`, 32'd50000: decrement of `speed_count` per completed row.
- `MIN_SPEED`, 32'd100000: saturation floor for `speed_count`.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `enable_frame` in 1: one-cycle movement tick from the frame delay counter.
- `start` in 1: single-cycle pulse that starts or restarts a game.
- `place` in 1: synchronized button level; the block acts on its rising edge only.
- `speed_count` out 32: reload value for the delay counter.
- `counter_enable` out 1: enable for the delay counter; high only in MOVE.
- `row_mask` out `COLS`: cells occupied by the moving segment.
- `row_index` out $clog2(`ROWS`): current row; 0 is the bottom row.
- `locked_mask` out `COLS`: result of the most recent lock, held until the next lock.
- `locked_row` out $clog2(`ROWS`): row that `locked_mask` belongs to.
- `wr_en` out 1: one-cycle strobe to board memory/draw logic.
- `game_over` out 1: level.
- `win` out 1: level.

## Operation
- Internal state: `pos` (leftmost column), `width`, `dir` (0 = right, 1 = left), `prev_mask`, `place_d`.
- `row_mask` has bits `pos`..`pos+width-1` set in MOVE and LOCK, and is 0 in all other states.
- FSM states: IDLE, MOVE, LOCK, OVER, WIN.
- IDLE/OVER/WIN + `start` → MOVE, with:
  - `pos`=0, `width`=`INIT_WIDTH`, `dir`=right, `row_index`=0;
  - `prev_mask`=all ones;
  - `speed_count`=`START_SPEED`;
  - `game_over`=`win`=0.
- MOVE + `enable_frame` (no place edge), moving right:
  - if `pos+width`==`COLS`: `dir`←left, `pos`←`pos-1` (reverse and step in the same tick);
  - else `pos`←`pos+1`.
- MOVE + `enable_frame` (no place edge), moving left:
  - if `pos`==0: `dir`←right, `pos`←1;
  - else `pos`←`pos-1`.
- MOVE + place edge (`place`&~`place_d`), moving to LOCK:
  - `locked_mask`←`row_mask`&`prev_mask`;
  - `locked_row`←`row_index`;
  - `wr_en`←1.
- Place edge and `enable_frame` in the same cycle: the place edge wins. `pos` is not advanced, and the lock uses the pre-tick `row_mask`.
- LOCK, always:
  - `wr_en`←0;
  - if `locked_mask`==0: `game_over`←1 and go to OVER;
  - else if `row_index`==`ROWS-1`: `win`←1 and go to WIN;
  - else continue to the next row (below).
- LOCK, next row:
  - `row_index`+1, `pos`=0, `dir`=right;
  - `width`←popcount(`locked_mask`); the overlap of two contiguous runs is contiguous;
  - `prev_mask`←`locked_mask`;
  - `speed_count`←max(`speed_count`−`SPEED_STEP`, `MIN_SPEED`), computed without unsigned underflow;
  - go to MOVE.
- `place` edges outside MOVE are ignored. `place_d` updates every cycle, so holding `place` high never retriggers.
- `start` in MOVE or LOCK is ignored.
- Reset (any time, including mid-LOCK), all asynchronous:
  - state IDLE;
  - `row_mask`, `locked_mask`, `locked_row`, `row_index` = 0;
  - `wr_en`, `counter_enable`, `game_over`, `win` = 0;
  - `speed_count`=`START_SPEED`;
  - `pos`=0, `width`=`INIT_WIDTH`, `dir`=right, `prev_mask`=all ones, `place_d`=0.

## Timing
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.
- Movement: `row_mask` updates on the clock edge that samples `enable_frame`=1.
- Place edge sampled at edge N, during cycle N+1:
  - state is LOCK, `wr_en`=1;
  - `locked_mask` and `locked_row` are valid, and stay stable until the next lock or reset.
- Edge N+1:
  - `wr_en` falls;
  - new `row_index`, `row_mask`, and `speed_count` are visible, or `game_over`/`win` rises.
- `counter_enable` is low for exactly one cycle (LOCK) between rows.
- `start` sampled at edge N: MOVE with the initial segment is visible in cycle N+1.

## Test plan
- **Reset then start:** reset, then `start` pulse → `row_mask`=10'b0000000111, `counter_enable`=1, `speed_count`=833332, `row_index`=0.
- **Bounce right:**
  - 7 `enable_frame` ticks → `row_mask`=10'b1110000000;
  - 8th tick → 10'b0111000000;
  - tick with `enable_frame` low → no change.
- **Full-overlap lock:**
  - row 0 at `pos`=2, `place` rises → one-cycle `wr_en`, `locked_mask`=10'b0000011100, `locked_row`=0;
  - next cycle → `row_index`=1, `row_mask`=10'b0000000111, `speed_count`=783332.
- **Partial overlap:** row 1 placed at `pos`=3 over previous 2..4 → `locked_mask`=10'b0000011000, next `row_mask`=10'b0000000011.
- **Miss:**
  - no overlap → `wr_en` pulse with `locked_mask`=0, `game_over`=1, `counter_enable`=0, `row_mask`=0;
  - `place` edges ignored;
  - `start` restarts with `game_over`=0.
- **Corners:**
  - `place` rise coincident with `enable_frame` → lock uses unmoved mask;
  - `place` held high → single lock;
  - `SPEED_STEP`=500000 → `speed_count` clamps at 100000;
  - `ROWS`=2 full-width placements → `win`=1;
  - `resetn` low during LOCK → IDLE immediately, `wr_en`=0.
